// File: rtl/br_wb_arbiter_pkg.sv
// Shared definitions for the BR writeback arbiter: default widths and grant encodings.
package br_wb_arbiter_pkg;

  localparam int unsigned AddrWDef = 5;
  localparam int unsigned DataWDef = 32;

  typedef enum logic {
    GntAlu = 1'b0,
    GntLd  = 1'b1
  } gnt_e;

endpackage

// File: rtl/br_scoreboard.sv
// Busy scoreboard for the register bank: one bit per register with a pending result.
module br_scoreboard #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_busy1,
  output logic              q_busy2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NumRegs-1:0] busy_q, busy_d;

  // Set is applied after clear so a newer producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign q_busy1 = (q_a1 != '0) && busy_q[q_a1];
  assign q_busy2 = (q_a2 != '0) && busy_q[q_a2];

endmodule

// File: rtl/br_wb_arbiter.sv
// Arbitrates the single BR write port between the ALU and load writeback paths and
// tracks in-flight destination registers.
module br_wb_arbiter
  import br_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              we3,
  output logic              grant_id,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_busy1,
  output logic              q_busy2
);

  gnt_e              last_grant_q;
  gnt_e              sel;
  logic              accept;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN && (last_grant_q == GntAlu)) req1_ready = 1'b1;
        else                                   req0_ready = 1'b1;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept  = req0_ready | req1_ready;
  assign sel     = req1_ready ? GntLd : GntAlu;
  assign wr_addr = req1_ready ? req1_addr : req0_addr;
  assign wr_data = req1_ready ? req1_data : req0_data;

  // Writes to x0 still consume the grant but never reach BR.
  always_ff @(posedge clk) begin
    if (rst) begin
      a3           <= '0;
      wd3          <= '0;
      we3          <= 1'b0;
      grant_id     <= 1'b0;
      last_grant_q <= GntLd;
    end else begin
      we3 <= 1'b0;
      if (accept) begin
        a3           <= wr_addr;
        wd3          <= wr_data;
        we3          <= (wr_addr != '0);
        grant_id     <= sel;
        last_grant_q <= sel;
      end
    end
  end

  br_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .clr_en   (we3),
    .clr_addr (a3),
    .q_a1     (q_a1),
    .q_a2     (q_a2),
    .q_busy1  (q_busy1),
    .q_busy2  (q_busy2)
  );

endmodule

// File: tb/tb_br_wb_arbiter.sv
// Randomised and directed bench for br_wb_arbiter; a round-robin and a fixed-priority
// instance share stimulus and are each checked against a behavioural model.
module tb_br_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        issue_valid;
  logic [4:0]  issue_rd, q_a1, q_a2;

  logic        ready0 [2];
  logic        ready1 [2];
  logic [4:0]  a3     [2];
  logic [31:0] wd3    [2];
  logic        we3    [2];
  logic        gid    [2];
  logic        qb1    [2];
  logic        qb2    [2];

  always #5 clk = ~clk;

  br_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(ready0[0]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(ready1[0]),
    .a3(a3[0]), .wd3(wd3[0]), .we3(we3[0]), .grant_id(gid[0]),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q_a1(q_a1), .q_a2(q_a2), .q_busy1(qb1[0]), .q_busy2(qb2[0])
  );

  br_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(ready0[1]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(ready1[1]),
    .a3(a3[1]), .wd3(wd3[1]), .we3(we3[1]), .grant_id(gid[1]),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q_a1(q_a1), .q_a2(q_a2), .q_busy1(qb1[1]), .q_busy2(qb2[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance (0 = round-robin, 1 = fixed priority)
  bit          m_lg   [2];
  bit [4:0]    m_a3   [2];
  bit [31:0]   m_wd3  [2];
  bit          m_we3  [2];
  bit          m_gid  [2];
  bit [31:0]   m_busy [2];
  bit          m_r0   [2];
  bit          m_r1   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lg[k] = 1'b1; m_a3[k] = '0; m_wd3[k] = '0; m_we3[k] = 1'b0;
      m_gid[k] = 1'b0; m_busy[k] = '0; m_r0[k] = 1'b0; m_r1[k] = 1'b0;
    end
  endtask

  // Checks both instances against the model at the falling edge, then advances the model
  // to the state it must hold after the coming rising edge.
  task automatic at_neg();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit rr, e0, e1, sel;
      rr = (k == 0);
      e0 = !rst && req0_valid && (!req1_valid || !rr || m_lg[k]);
      e1 = !rst && req1_valid && !e0;
      chk($sformatf("ready0[%0d]", k), ready0[k], e0);
      chk($sformatf("ready1[%0d]", k), ready1[k], e1);
      chk($sformatf("we3[%0d]", k), we3[k], m_we3[k]);
      if (m_we3[k]) begin
        chk($sformatf("a3[%0d]", k), a3[k], m_a3[k]);
        chk($sformatf("wd3[%0d]", k), wd3[k], m_wd3[k]);
        chk($sformatf("grant_id[%0d]", k), gid[k], m_gid[k]);
      end
      chk($sformatf("q_busy1[%0d]", k), qb1[k], (q_a1 != 0) && m_busy[k][q_a1]);
      chk($sformatf("q_busy2[%0d]", k), qb2[k], (q_a2 != 0) && m_busy[k][q_a2]);
      m_r0[k] = e0;
      m_r1[k] = e1;
      if (rst) begin
        m_lg[k] = 1'b1; m_a3[k] = '0; m_wd3[k] = '0; m_we3[k] = 1'b0;
        m_gid[k] = 1'b0; m_busy[k] = '0;
      end else begin
        if (m_we3[k]) m_busy[k][m_a3[k]] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[k][issue_rd] = 1'b1;
        if (e0 || e1) begin
          sel      = e1;
          m_a3[k]  = sel ? req1_addr : req0_addr;
          m_wd3[k] = sel ? req1_data : req0_data;
          m_we3[k] = (m_a3[k] != 0);
          m_gid[k] = sel;
          m_lg[k]  = sel;
        end else begin
          m_we3[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h8;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h10;
    issue_valid = 1'b0; issue_rd = '0; q_a1 = 5'd5; q_a2 = 5'd6;

    // Reset held two cycles with both requesters valid
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("rst ready0", ready0[0], 1'b0);
      chk("rst ready1", ready1[0], 1'b0);
      chk("rst we3", we3[0], 1'b0);
      chk("rst q_busy1", qb1[0], 1'b0);
      tick();
    end
    rst = 1'b0;

    // Round-robin from reset: req0 first, req1 next
    at_neg();
    chk("rr first ready0", ready0[0], 1'b1);
    chk("rr first ready1", ready1[0], 1'b0);
    tick();
    req0_valid = 1'b0;
    at_neg();
    chk("rr second ready1", ready1[0], 1'b1);
    chk("rr a3", a3[0], 32'd5);
    chk("rr wd3", wd3[0], 32'h8);
    chk("rr we3", we3[0], 1'b1);
    chk("rr grant", gid[0], 1'b0);
    tick();
    req1_valid = 1'b0;
    at_neg();
    chk("rr2 a3", a3[0], 32'd6);
    chk("rr2 wd3", wd3[0], 32'h10);
    chk("rr2 grant", gid[0], 1'b1);
    tick();

    // Fixed priority with req0 held valid: req1 never granted
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_addr = 5'(i + 10); req0_data = 32'(i);
      at_neg();
      chk("fp ready1", ready1[1], 1'b0);
      chk("fp ready0", ready0[1], 1'b1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    at_neg(); tick();

    // Scoreboard set, then clear by a write to the same register
    q_a1 = 5'd4; issue_valid = 1'b1; issue_rd = 5'd4;
    at_neg(); tick();
    issue_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h4;
    at_neg();
    chk("sb busy after issue", qb1[0], 1'b1);
    chk("single ready0", ready0[0], 1'b1);
    tick();
    req0_valid = 1'b0;
    at_neg();
    chk("single we3", we3[0], 1'b1);
    chk("single a3", a3[0], 32'd4);
    chk("single wd3", wd3[0], 32'h4);
    chk("single grant", gid[0], 1'b0);
    tick();
    at_neg();
    chk("sb cleared", qb1[0], 1'b0);
    tick();

    // Same-edge set and clear: set wins
    issue_valid = 1'b1; issue_rd = 5'd4;
    at_neg(); tick();
    issue_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    at_neg(); tick();
    req0_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd4;
    at_neg();
    chk("same-edge we3", we3[0], 1'b1);
    chk("same-edge a3", a3[0], 32'd4);
    tick();
    issue_valid = 1'b0;
    at_neg();
    chk("same-edge busy", qb1[0], 1'b1);
    tick();

    // Write to x0: accepted but never enabled
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF; q_a2 = 5'd0;
    at_neg();
    chk("x0 ready1", ready1[0], 1'b1);
    tick();
    req1_valid = 1'b0;
    at_neg();
    chk("x0 we3", we3[0], 1'b0);
    chk("x0 q_busy2", qb2[0], 1'b0);
    tick();

    // Random phase; requests are held until the round-robin instance accepts them
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!req0_valid || m_r0[0]) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_addr  = 5'($urandom);
        req0_data  = $urandom;
      end
      if (!req1_valid || m_r1[0]) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_addr  = 5'($urandom);
        req1_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom);
      q_a1        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      q_a2        = 5'($urandom);
      at_neg();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
